// File: rtl/fifo_rd_stream_if.sv
// Pop-side FIFO signals and the downstream valid/ready stream of the read consumer.
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             rempty;
  logic [WIDTH-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read consumer: pops into a 3-entry prefetch buffer and presents a valid/ready stream.
// Pops depend only on registered occupancy, so m_ready never reaches rinc combinationally.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrstn,
  fifo_rd_stream_if.master     bus,
  output logic [1:0]           level,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  localparam int unsigned           DEPTH   = 3;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  logic [WIDTH-1:0]     buf_q [DEPTH];
  logic [WIDTH-1:0]     buf_d [DEPTH];
  logic [1:0]           head_q, head_d;
  logic [1:0]           tail_q, tail_d;
  logic [1:0]           level_q, level_d;
  logic                 inflight_q, inflight_d;
  logic                 m_valid_q, m_valid_d;
  logic [WIDTH-1:0]     m_data_q, m_data_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic [2:0]           occupancy_c;
  logic                 pop_c;
  logic                 xfer_c;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A word is either buffered or returning from the FIFO; never commit more than 3.
  assign occupancy_c = 3'(level_q) + 3'(inflight_q);
  assign pop_c       = rrstn & ~bus.rempty & (occupancy_c <= 3'd2);
  assign xfer_c      = m_valid_q & bus.m_ready;

  assign bus.rinc    = pop_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign level       = level_q;
  assign beat_cnt    = beat_cnt_q;

  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    inflight_d = pop_c;
    beat_cnt_d = beat_cnt_q;

    if (inflight_q) begin
      buf_d[tail_q] = bus.rdata;
      tail_d        = ptr_inc(tail_q);
    end

    if (xfer_c) begin
      head_d = ptr_inc(head_q);
      if (beat_cnt_q != CNT_MAX) begin
        beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      end
    end

    case ({inflight_q, xfer_c})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase

    // Output word is registered from next-state head so it holds while stalled.
    m_valid_d = (level_d != 2'd0);
    m_data_d  = buf_d[head_d];
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a FIFO pop model feeds the DUT, a monitor checks stream order.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH         = 8;
  localparam int unsigned CNT_WIDTH     = 16;
  localparam int unsigned SAT_CNT_WIDTH = 4;
  localparam int          SAT_WORDS     = 20;

  logic rclk  = 1'b0;
  logic rrstn = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();
  fifo_rd_stream_if #(.WIDTH(WIDTH)) bus2 ();

  logic [1:0]               level, level2;
  logic [CNT_WIDTH-1:0]     beat_cnt;
  logic [SAT_CNT_WIDTH-1:0] beat_cnt2;

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_dut (
    .rclk     (rclk),
    .rrstn    (rrstn),
    .bus      (bus.master),
    .level    (level),
    .beat_cnt (beat_cnt)
  );

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_WIDTH(SAT_CNT_WIDTH)) u_sat (
    .rclk     (rclk),
    .rrstn    (rrstn),
    .bus      (bus2.master),
    .level    (level2),
    .beat_cnt (beat_cnt2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  logic [WIDTH-1:0] fifo_q [$];
  logic [WIDTH-1:0] exp_q  [$];
  logic             gap  = 1'b0;
  logic             infl = 1'b0;
  int               cyc  = 0;

  // FIFO read-side model: registered rempty, rdata one cycle after an accepted pop.
  always @(posedge rclk) begin
    cyc <= cyc + 1;
    if (!rrstn) begin
      bus.rempty <= 1'b1;
      infl       <= 1'b0;
    end else begin
      infl <= bus.rinc;
      if (bus.rinc) begin
        check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) bus.rdata <= fifo_q.pop_front();
      end
      bus.rempty <= (fifo_q.size() == 0) || gap;
    end
  end

  int rinc_cnt, rinc_first, rinc_last;
  int xf_cnt, xf_first, xf_last, re_first;
  logic [WIDTH-1:0] first_data;
  logic             stall_q = 1'b0;
  logic [WIDTH-1:0] stall_data;

  task automatic clear_stats();
    rinc_cnt = 0; rinc_first = -1; rinc_last = -1;
    xf_cnt = 0; xf_first = -1; xf_last = -1; re_first = -1;
  endtask

  // Stream monitor: scoreboard order, stall stability and occupancy invariants.
  always @(negedge rclk) begin
    if (!rrstn) begin
      stall_q = 1'b0;
    end else begin
      check("occupancy_le_3", 32'(32'(level) + 32'(infl) <= 32'd3), 32'd1);
      check("no_rinc_when_empty", 32'(bus.rinc & bus.rempty), 32'd0);
      if (stall_q) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(stall_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("m_data_order", 32'(bus.m_data), 32'(exp_q.pop_front()));
        if (xf_cnt == 0) begin
          xf_first   = cyc;
          first_data = bus.m_data;
        end
        xf_last = cyc;
        xf_cnt++;
      end
      if (bus.rinc) begin
        if (rinc_cnt == 0) rinc_first = cyc;
        rinc_last = cyc;
        rinc_cnt++;
      end
      if (!bus.rempty && re_first < 0) re_first = cyc;
      stall_q    = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end
  end

  // Saturation instance: a stream of SAT_WORDS words whose value is their index.
  logic en2   = 1'b0;
  int   sent2 = 0;
  int   xf2   = 0;

  always @(posedge rclk) begin
    if (!rrstn) begin
      bus2.rempty <= 1'b1;
      sent2       <= 0;
    end else begin
      if (bus2.rinc) begin
        bus2.rdata <= 8'(sent2);
        sent2      <= sent2 + 1;
      end
      bus2.rempty <= !(en2 && (sent2 + int'(bus2.rinc)) < SAT_WORDS);
    end
  end

  always @(negedge rclk) begin
    if (rrstn && bus2.m_valid && bus2.m_ready) begin
      check("sat_data", 32'(bus2.m_data), 32'(xf2));
      check("sat_beat_cnt", 32'(beat_cnt2), (xf2 > 15) ? 32'd15 : 32'(xf2));
      xf2++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && level == 2'd0 && !bus.rinc) && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_done_in_budget"}, 32'(k < budget), 32'd1);
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int pushed;
    int k;
    bus.m_ready  = 1'b0;
    bus2.m_ready = 1'b1;
    clear_stats();
    tick(3);

    // Reset state.
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_rinc", 32'(bus.rinc), 32'd0);
    rrstn = 1'b1;
    tick(2);

    // Single word.
    clear_stats();
    bus.m_ready = 1'b1;
    push(8'hA5);
    wait_idle("single", 50);
    check("single_rinc_pulses", 32'(rinc_cnt), 32'd1);
    check("single_beats", 32'(xf_cnt), 32'd1);
    check("single_latency", 32'(xf_first - re_first), 32'd2);
    check("single_beat_cnt", 32'(beat_cnt), 32'd1);
    check("single_level", 32'(level), 32'd0);

    // Burst of 16 prefilled words.
    clear_stats();
    for (int i = 0; i < 16; i++) push(8'(i));
    wait_idle("burst", 100);
    check("burst_rinc_pulses", 32'(rinc_cnt), 32'd16);
    check("burst_rinc_span", 32'(rinc_last - rinc_first), 32'd15);
    check("burst_beats", 32'(xf_cnt), 32'd16);
    check("burst_beat_span", 32'(xf_last - xf_first), 32'd15);
    check("burst_beat_cnt", 32'(beat_cnt), 32'd17);
    check("burst_rempty", 32'(bus.rempty), 32'd1);

    // Backpressure: only three words may be outstanding.
    clear_stats();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    tick(10);
    check("bp_rinc_pulses", 32'(rinc_cnt), 32'd3);
    check("bp_level", 32'(level), 32'd3);
    check("bp_rinc_low", 32'(bus.rinc), 32'd0);
    check("bp_head_data", 32'(bus.m_data), 32'h30);
    bus.m_ready = 1'b1;
    wait_idle("bp", 100);
    check("bp_beats", 32'(xf_cnt), 32'd8);
    check("bp_beat_span", 32'(xf_last - xf_first), 32'd7);
    check("bp_beat_cnt", 32'(beat_cnt), 32'd25);

    // Random stalls and rempty gaps.
    clear_stats();
    pushed = 0;
    k = 0;
    while (!(pushed == 100 && exp_q.size() == 0) && k < 4000) begin
      if (pushed < 100 && $urandom_range(0, 1) == 1) begin
        push(8'((pushed * 37 + 11) & 255));
        pushed++;
      end
      bus.m_ready = $urandom_range(0, 1) == 1;
      gap         = $urandom_range(0, 3) == 0;
      tick(1);
      k++;
    end
    bus.m_ready = 1'b1;
    gap         = 1'b0;
    wait_idle("rand", 200);
    check("rand_beats", 32'(xf_cnt), 32'd100);
    check("rand_beat_cnt", 32'(beat_cnt), 32'd125);

    // Reset with two words buffered and one in flight.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    k = 0;
    while (!(level == 2'd2 && infl) && k < 20) begin
      tick(1);
      k++;
    end
    check("mid_state_reached", 32'(k < 20), 32'd1);
    #2;
    rrstn = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("mid_rst_rinc", 32'(bus.rinc), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    tick(2);
    rrstn = 1'b1;
    bus.m_ready = 1'b1;
    clear_stats();
    push(8'hC1);
    push(8'hC2);
    wait_idle("post_rst", 50);
    check("post_rst_first", 32'(first_data), 32'hC1);
    check("post_rst_beats", 32'(xf_cnt), 32'd2);
    check("post_rst_beat_cnt", 32'(beat_cnt), 32'd2);

    // Saturating counter on the narrow-count instance.
    en2 = 1'b1;
    k = 0;
    while (xf2 < SAT_WORDS && k < 200) begin
      tick(1);
      k++;
    end
    tick(3);
    check("sat_words", 32'(xf2), 32'd20);
    check("sat_final_cnt", 32'(beat_cnt2), 32'd15);
    check("sat_level", 32'(level2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
